// File: rtl/nv_ram_pdp_256x11_fifo_ctrl.sv
// Initiator-side controller for the 256x11 pseudo-dual-port RAM. It converts push/pop handshakes into
// RAM port cycles and hides the 1-cycle read latency behind a 2-entry skid. Optional: IDLE_SLEEP_EN.
module nv_ram_pdp_256x11_fifo_ctrl #(
   parameter int AW          = 8,
   parameter int DW          = 11,
   parameter int SLEEP_IDLE  = 16,
   parameter int WAKE_CYCLES = 2
) (
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rstn,
   input  logic          wr_pvld,
   output logic          wr_prdy,
   input  logic [DW-1:0] wr_pd,
   output logic          rd_pvld,
   input  logic          rd_prdy,
   output logic [DW-1:0] rd_pd,
   output logic          ram_we,
   output logic [AW-1:0] ram_wa,
   output logic [DW-1:0] ram_wd,
   output logic          ram_re,
   output logic [AW-1:0] ram_ra,
   input  logic [DW-1:0] ram_rd,
   output logic [7:0]    ram_sleep_en,
   output logic          ram_ret_en,
   output logic [AW:0]   fifo_count
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   if (SLEEP_IDLE < 1 || WAKE_CYCLES < 1) begin : g_bad_cfg
      $error("SLEEP_IDLE and WAKE_CYCLES must both be at least 1");
   end

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   ram_cnt_q, ram_cnt_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [DW-1:0] skid0_q, skid0_d;
   logic [DW-1:0] skid1_q, skid1_d;
   logic [1:0]    skid_cnt_q, skid_cnt_d;
   logic          inflight_q, inflight_d;
   logic          active;
   logic          accept;
   logic          pop;
   logic          issue;
   logic [2:0]    occ;

`ifdef IDLE_SLEEP_EN
   localparam int IW = $clog2(SLEEP_IDLE + 1);
   localparam int WW = $clog2(WAKE_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_SLEEP  = 2'd1,
      ST_WAKE   = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [WW-1:0] wake_q, wake_d;

   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      case (state_q)
         ST_ACTIVE: begin
            if (cnt_q == '0 && !wr_pvld) begin
               if (idle_q == IW'(SLEEP_IDLE - 1)) begin
                  state_d = ST_SLEEP;
                  idle_d  = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end else begin
               idle_d = '0;
            end
         end
         ST_SLEEP: begin
            if (wr_pvld) begin
               state_d = ST_WAKE;
               wake_d  = '0;
            end
         end
         ST_WAKE: begin
            if (wake_q == WW'(WAKE_CYCLES - 1)) begin
               state_d = ST_ACTIVE;
            end else begin
               wake_d = wake_q + 1'b1;
            end
         end
         default: state_d = ST_ACTIVE;
      endcase
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q <= ST_ACTIVE;
         idle_q  <= '0;
         wake_q  <= '0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         wake_q  <= wake_d;
      end
   end

   assign active       = (state_q == ST_ACTIVE);
   assign ram_sleep_en = (state_q == ST_SLEEP) ? 8'hFF : 8'h00;
   assign ram_ret_en   = (state_q == ST_SLEEP);
`else
   assign active       = 1'b1;
   assign ram_sleep_en = 8'h00;
   assign ram_ret_en   = 1'b0;
`endif

   // A read issued this cycle only returns next cycle, so count it against skid space now.
   always_comb begin
      wr_prdy = active && (ram_cnt_q < DEPTH);
      accept  = wr_pvld && wr_prdy;
      rd_pvld = (skid_cnt_q != 2'd0);
      rd_pd   = skid0_q;
      pop     = rd_pvld && rd_prdy;
      occ     = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue   = active && (ram_cnt_q != '0) && (occ < 3'd2);
      ram_we  = accept;
      ram_wa  = wr_ptr_q;
      ram_wd  = wr_pd;
      ram_re  = issue;
      ram_ra  = rd_ptr_q;
   end

   always_comb begin
      wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
      inflight_d = issue;
      ram_cnt_d  = ram_cnt_q;
      if (accept && !issue) begin
         ram_cnt_d = ram_cnt_q + 1'b1;
      end else if (!accept && issue) begin
         ram_cnt_d = ram_cnt_q - 1'b1;
      end
      cnt_d = cnt_q;
      if (accept && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!accept && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Pop retires the head first, then returning RAM data lands in the first free slot.
   always_comb begin
      skid0_d    = skid0_q;
      skid1_d    = skid1_q;
      skid_cnt_d = skid_cnt_q;
      if (pop) begin
         skid0_d    = skid1_q;
         skid_cnt_d = skid_cnt_q - 2'd1;
      end
      if (inflight_q) begin
         if (skid_cnt_d == 2'd0) begin
            skid0_d = ram_rd;
         end else begin
            skid1_d = ram_rd;
         end
         skid_cnt_d = skid_cnt_d + 2'd1;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         cnt_q      <= '0;
         skid0_q    <= '0;
         skid1_q    <= '0;
         skid_cnt_q <= 2'd0;
         inflight_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         cnt_q      <= cnt_d;
         skid0_q    <= skid0_d;
         skid1_q    <= skid1_d;
         skid_cnt_q <= skid_cnt_d;
         inflight_q <= inflight_d;
      end
   end

   assign fifo_count = cnt_q;

endmodule

// File: tb/tb_nv_ram_pdp_256x11_fifo_ctrl.sv
// Self-checking bench for nv_ram_pdp_256x11_fifo_ctrl: vector table, fill/stream/backpressure runs against a
// queue model, asynchronous reset, and the idle-sleep sequence when IDLE_SLEEP_EN is defined.
module tb_nv_ram_pdp_256x11_fifo_ctrl;

   logic        clk;
   logic        rstn;
   logic        wr_pvld;
   logic        wr_prdy;
   logic [10:0] wr_pd;
   logic        rd_pvld;
   logic        rd_prdy;
   logic [10:0] rd_pd;
   logic        ram_we;
   logic [7:0]  ram_wa;
   logic [10:0] ram_wd;
   logic        ram_re;
   logic [7:0]  ram_ra;
   logic [10:0] ram_rd;
   logic [7:0]  ram_sleep_en;
   logic        ram_ret_en;
   logic [8:0]  fifo_count;

   int total;
   int bad;
   int wr_total;
   int rd_total;
   int pop_total;
   logic        last_acc;
   logic        last_pop;
   logic [10:0] last_pop_pd;
   logic [10:0] q[$];
   logic [10:0] mem[0:255];

   typedef struct {
      logic        wv;
      logic [10:0] pd;
      logic        rp;
      logic        e_wr_prdy;
      logic        e_we;
      logic        e_re;
      logic        e_rd_pvld;
      logic        chk_pd;
      logic [10:0] e_rd_pd;
      logic [8:0]  e_cnt;
   } vec_t;

   vec_t tbl[10];

   nv_ram_pdp_256x11_fifo_ctrl dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .wr_pvld        (wr_pvld),
      .wr_prdy        (wr_prdy),
      .wr_pd          (wr_pd),
      .rd_pvld        (rd_pvld),
      .rd_prdy        (rd_prdy),
      .rd_pd          (rd_pd),
      .ram_we         (ram_we),
      .ram_wa         (ram_wa),
      .ram_wd         (ram_wd),
      .ram_re         (ram_re),
      .ram_ra         (ram_ra),
      .ram_rd         (ram_rd),
      .ram_sleep_en   (ram_sleep_en),
      .ram_ret_en     (ram_ret_en),
      .fifo_count     (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the RAM macro: synchronous write, registered read data.
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_wd;
      if (ram_re) ram_rd <= mem[ram_ra];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic wv, input logic [10:0] pd, input logic rp);
      @(negedge clk);
      wr_pvld = wv;
      wr_pd   = pd;
      rd_prdy = rp;
      #1;
   endtask

   task automatic resetDut();
      wr_pvld = 1'b0;
      wr_pd   = '0;
      rd_prdy = 1'b0;
      rstn    = 1'b0;
      repeat (2) @(negedge clk);
      q.delete();
      wr_total  = 0;
      rd_total  = 0;
      pop_total = 0;
      rstn      = 1'b1;
      #1;
   endtask

   // Reference model: the FIFO is a queue of accepted words; addresses are running counts mod 256.
   task automatic modelCycle();
      logic acc;
      logic pop;
      acc = wr_pvld & wr_prdy;
      pop = rd_pvld & rd_prdy;
      checkOutput("fifo_count", 32'(fifo_count), 32'(q.size()));
`ifndef IDLE_SLEEP_EN
      if (q.size() < 256) checkOutput("wr_prdy_room", 32'(wr_prdy), 32'd1);
      checkOutput("sleep_en_off", 32'(ram_sleep_en), 32'd0);
`endif
      if (q.size() >= 258) checkOutput("wr_prdy_full", 32'(wr_prdy), 32'd0);
      if (q.size() == 0) checkOutput("rd_pvld_empty", 32'(rd_pvld), 32'd0);
      checkOutput("ram_we", 32'(ram_we), 32'(acc));
      if (acc) begin
         checkOutput("ram_wa", 32'(ram_wa), 32'(wr_total[7:0]));
         checkOutput("ram_wd", 32'(ram_wd), 32'(wr_pd));
      end
      if (ram_re) begin
         checkOutput("ram_ra", 32'(ram_ra), 32'(rd_total[7:0]));
         rd_total++;
      end
      if (ram_we && ram_re) checkOutput("addr_distinct", 32'(ram_wa != ram_ra), 32'd1);
      if (pop && q.size() > 0) begin
         checkOutput("rd_pd", 32'(rd_pd), 32'(q[0]));
         last_pop_pd = rd_pd;
         void'(q.pop_front());
         pop_total++;
      end
      if (acc) begin
         q.push_back(wr_pd);
         wr_total++;
      end
      last_acc = acc;
      last_pop = pop;
   endtask

   task automatic drainAll(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
         applyStimulus(1'b0, 11'h000, 1'b1);
         modelCycle();
         n++;
      end
      checkOutput({name, "_drained"}, 32'(q.size()), 32'd0);
      applyStimulus(1'b0, 11'h000, 1'b0);
      checkOutput({name, "_rd_pvld"}, 32'(rd_pvld), 32'd0);
      checkOutput({name, "_count"}, 32'(fifo_count), 32'd0);
   endtask

   initial begin
      int acc_n;
      int cyc;
      total     = 0;
      bad       = 0;
      last_acc  = 1'b0;
      last_pop  = 1'b0;
      last_pop_pd = '0;

      // Fields: wv, pd, rp | wr_prdy, ram_we, ram_re, rd_pvld, chk_pd, rd_pd, fifo_count
      tbl[0] = '{1'b1, 11'h5A5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000, 9'd0};
      tbl[1] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 9'd1};
      tbl[2] = '{1'b1, 11'h123, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 9'd1};
      tbl[3] = '{1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 11'h5A5, 9'd2};
      tbl[4] = '{1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 9'd1};
      tbl[5] = '{1'b1, 11'h7FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 11'h123, 9'd1};
      tbl[6] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 9'd1};
      tbl[7] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 9'd1};
      tbl[8] = '{1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 11'h7FF, 9'd1};
      tbl[9] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 9'd0};

      resetDut();
      checkOutput("rst_wr_prdy", 32'(wr_prdy), 32'd1);
      checkOutput("rst_rd_pvld", 32'(rd_pvld), 32'd0);
      checkOutput("rst_rd_pd", 32'(rd_pd), 32'd0);
      checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
      checkOutput("rst_ram_re", 32'(ram_re), 32'd0);
      checkOutput("rst_count", 32'(fifo_count), 32'd0);
      checkOutput("rst_sleep_en", 32'(ram_sleep_en), 32'd0);
      checkOutput("rst_ret_en", 32'(ram_ret_en), 32'd0);

      // Vector table: single-word latency and skid behaviour cycle by cycle.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(tbl[i].wv, tbl[i].pd, tbl[i].rp);
         checkOutput($sformatf("vec%0d_wr_prdy", i), 32'(wr_prdy), 32'(tbl[i].e_wr_prdy));
         checkOutput($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].e_we));
         checkOutput($sformatf("vec%0d_ram_re", i), 32'(ram_re), 32'(tbl[i].e_re));
         checkOutput($sformatf("vec%0d_rd_pvld", i), 32'(rd_pvld), 32'(tbl[i].e_rd_pvld));
         if (tbl[i].chk_pd) checkOutput($sformatf("vec%0d_rd_pd", i), 32'(rd_pd), 32'(tbl[i].e_rd_pd));
         checkOutput($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      end

      // Fill with the reader stalled: 256 RAM words plus 2 skid words, then drain in order.
      resetDut();
      acc_n = 0;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 11'(acc_n), 1'b0);
         modelCycle();
         if (last_acc) acc_n++;
      end
      checkOutput("fill_accepted", 32'(acc_n), 32'd258);
      checkOutput("fill_wr_prdy", 32'(wr_prdy), 32'd0);
      checkOutput("fill_count", 32'(fifo_count), 32'd258);
      drainAll("fill");
      checkOutput("fill_pops", 32'(pop_total), 32'd258);
      checkOutput("fill_last_pd", 32'(last_pop_pd), 32'd257);

      // Full-rate streaming across two pointer wraps.
      resetDut();
      acc_n = 0;
      cyc   = 0;
      while (acc_n < 600 && cyc < 700) begin
         applyStimulus(1'b1, 11'(acc_n), 1'b1);
         checkOutput("stream_wr_prdy", 32'(wr_prdy), 32'd1);
         if (cyc >= 3) checkOutput("stream_rd_pvld", 32'(rd_pvld), 32'd1);
         modelCycle();
         if (last_acc) acc_n++;
         cyc++;
      end
      checkOutput("stream_accepted", 32'(acc_n), 32'd600);
      drainAll("stream");
      checkOutput("stream_pops", 32'(pop_total), 32'd600);

      // Continuous push with random reader backpressure.
      resetDut();
      acc_n = 0;
      cyc   = 0;
      while (acc_n < 1000 && cyc < 5000) begin
         applyStimulus(1'b1, 11'($urandom), 1'($urandom_range(0, 1)));
         modelCycle();
         if (last_acc) acc_n++;
         cyc++;
      end
      checkOutput("bp_accepted", 32'(acc_n), 32'd1000);
      drainAll("bp");
      checkOutput("bp_pops", 32'(pop_total), 32'd1000);

      // Asynchronous reset with 100 words held, then a fresh word must come out first.
      resetDut();
      cyc = 0;
      while (wr_total < 100 && cyc < 200) begin
         applyStimulus(1'b1, 11'(wr_total + 7), 1'b0);
         modelCycle();
         cyc++;
      end
      applyStimulus(1'b0, 11'h000, 1'b0);
      checkOutput("prerst_count", 32'(fifo_count), 32'd100);
      #2 rstn = 1'b0;
      #1;
      checkOutput("arst_wr_prdy", 32'(wr_prdy), 32'd1);
      checkOutput("arst_rd_pvld", 32'(rd_pvld), 32'd0);
      checkOutput("arst_rd_pd", 32'(rd_pd), 32'd0);
      checkOutput("arst_ram_we", 32'(ram_we), 32'd0);
      checkOutput("arst_ram_re", 32'(ram_re), 32'd0);
      checkOutput("arst_count", 32'(fifo_count), 32'd0);
      checkOutput("arst_sleep_en", 32'(ram_sleep_en), 32'd0);
      checkOutput("arst_ret_en", 32'(ram_ret_en), 32'd0);
      @(negedge clk);
      q.delete();
      wr_total  = 0;
      rd_total  = 0;
      pop_total = 0;
      rstn      = 1'b1;
      applyStimulus(1'b1, 11'h001, 1'b1);
      modelCycle();
      cyc = 0;
      while (pop_total == 0 && cyc < 20) begin
         applyStimulus(1'b0, 11'h000, 1'b1);
         modelCycle();
         cyc++;
      end
      checkOutput("postrst_popped", 32'(pop_total), 32'd1);
      checkOutput("postrst_first_pd", 32'(last_pop_pd), 32'h001);

`ifdef IDLE_SLEEP_EN
      // Idle sleep: 16 empty cycles to SLEEP, then 1 + 2 stalled cycles on wake.
      resetDut();
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 11'h000, 1'b0);
      checkOutput("presleep_sleep_en", 32'(ram_sleep_en), 32'd0);
      applyStimulus(1'b0, 11'h000, 1'b0);
      checkOutput("sleep_sleep_en", 32'(ram_sleep_en), 32'hFF);
      checkOutput("sleep_ret_en", 32'(ram_ret_en), 32'd1);
      checkOutput("sleep_wr_prdy", 32'(wr_prdy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 11'h2C3, 1'b1);
         checkOutput($sformatf("wake%0d_wr_prdy", i), 32'(wr_prdy), 32'd0);
         if (i > 0) begin
            checkOutput($sformatf("wake%0d_sleep_en", i), 32'(ram_sleep_en), 32'd0);
            checkOutput($sformatf("wake%0d_ret_en", i), 32'(ram_ret_en), 32'd0);
         end
         modelCycle();
      end
      applyStimulus(1'b1, 11'h2C3, 1'b1);
      checkOutput("wake_accept", 32'(wr_prdy), 32'd1);
      modelCycle();
      drainAll("wake");
      checkOutput("wake_pd", 32'(last_pop_pd), 32'h2C3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
